fifo_sync_ext: RTL and testbench

FIFO_SYNC_EXT -- requirements
Module: fifo_sync_ext

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_sync_ext.sv | 189 ++++++++++++++++++
 tb/tb_fifo_sync_ext.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  // How the read port presents data to the consumer.
  typedef enum logic {
    RD_REGISTERED = 1'b0,  // o_data registered on an accepted read
    RD_FWFT       = 1'b1   // head word shown combinationally, i_rd pops it
  } rd_mode_e;

  // Map the integer mode parameter onto the enumeration.
  function automatic rd_mode_e rd_mode_of(input int fwft);
    return (fwft != 0) ? RD_FWFT : RD_REGISTERED;
  endfunction

  // Legal thresholds: 1 <= aempty < afull <= number of entries.
  function automatic bit thresholds_ok(input int depth_log2,
                                       input int afull_th,
                                       input int aempty_th);
    return (aempty_th >= 1) &&
           (aempty_th < afull_th) &&
           (afull_th <= (1 << depth_log2));
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after i_we; read is combinational.
// Backpressure: none, the caller decides when a write is legal.
module fifo_ram #(
  parameter int G_WIDTH = 8,
  parameter int G_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [G_DEPTH-1:0] i_waddr,
  input  logic [G_WIDTH-1:0] i_wdata,
  input  logic [G_DEPTH-1:0] i_raddr,
  output logic [G_WIDTH-1:0] o_rdata
);

  // Contents are deliberately not reset; the pointers define what is valid.
  logic [G_WIDTH-1:0] r_mem [0:(2**G_DEPTH)-1];

  // Store the incoming word on an enabled write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with level, almost-full/empty flags and sticky error reporting.
// Latency: registered mode returns data the cycle after the read; FWFT shows a new word the cycle after the write.
// Backpressure: writes while full are dropped (o_overflow) unless a read frees a slot in the same cycle.
module fifo_sync_ext
  import fifo_pkg::*;
#(
  parameter int G_WIDTH     = 8,
  parameter int G_DEPTH     = 4,
  parameter int G_FWFT      = 0,
  parameter int G_AFULL_TH  = 2**G_DEPTH-1,
  parameter int G_AEMPTY_TH = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_rd,
  input  logic               i_clr_err,
  output logic [G_WIDTH-1:0] o_data,
  output logic               o_rd_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_afull,
  output logic               o_aempty,
  output logic [G_DEPTH:0]   o_level,
  output logic               o_overflow,
  output logic               o_underflow,
  output logic               o_ovf_sticky,
  output logic               o_udf_sticky
);

  localparam rd_mode_e         LP_MODE      = rd_mode_of(G_FWFT);
  localparam logic [G_DEPTH:0] LP_FULL_LVL  = {1'b1, {G_DEPTH{1'b0}}};
  localparam logic [G_DEPTH:0] LP_AFULL_TH  = (G_DEPTH+1)'(G_AFULL_TH);
  localparam logic [G_DEPTH:0] LP_AEMPTY_TH = (G_DEPTH+1)'(G_AEMPTY_TH);

  // Reject inconsistent thresholds before anything gets built.
  if (!thresholds_ok(G_DEPTH, G_AFULL_TH, G_AEMPTY_TH)) begin : g_bad_thresholds
    $error("fifo_sync_ext: need 1 <= G_AEMPTY_TH < G_AFULL_TH <= 2**G_DEPTH");
  end

  // One extra pointer bit separates full from empty when the index bits match.
  logic [G_DEPTH:0]   r_wr_ptr;
  logic [G_DEPTH:0]   r_rd_ptr;
  logic               r_ovf_sticky;
  logic               r_udf_sticky;

  logic [G_DEPTH:0]   w_level;
  logic               w_empty;
  logic               w_full;
  logic               w_rd_accept;
  logic               w_wr_accept;
  logic               w_overflow;
  logic               w_underflow;
  logic               w_ram_we;
  logic [G_WIDTH-1:0] w_ram_rdata;

  // Status is purely a function of the registered pointers.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == LP_FULL_LVL);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign w_rd_accept = i_rd && !w_empty;
  assign w_wr_accept = i_wr && (!w_full || w_rd_accept);
  assign w_overflow  = i_wr && w_full && !w_rd_accept;
  assign w_underflow = i_rd && w_empty;

  // Reset wins over any write, so nothing lands in memory during reset.
  assign w_ram_we = w_wr_accept && i_rst_n;

  fifo_ram #(
    .G_WIDTH (G_WIDTH),
    .G_DEPTH (G_DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[G_DEPTH-1:0]),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr[G_DEPTH-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Advance the pointers on accepted requests; they wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_accept) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Latch error events until cleared; a new event beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_udf_sticky <= 1'b0;
    end else begin
      if (w_overflow) begin
        r_ovf_sticky <= 1'b1;
      end else if (i_clr_err) begin
        r_ovf_sticky <= 1'b0;
      end
      if (w_underflow) begin
        r_udf_sticky <= 1'b1;
      end else if (i_clr_err) begin
        r_udf_sticky <= 1'b0;
      end
    end
  end

  if (LP_MODE == RD_FWFT) begin : g_fwft
    // Head word is always on the bus; valid simply mirrors "not empty".
    assign o_data     = w_ram_rdata;
    assign o_rd_valid = !w_empty;
  end else begin : g_registered
    logic [G_WIDTH-1:0] r_data;
    logic               r_rd_valid;

    // Capture the head word on an accepted read and flag it for one cycle.
    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_data     <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_accept;
        if (w_rd_accept) begin
          r_data <= w_ram_rdata;
        end
      end
    end

    assign o_data     = r_data;
    assign o_rd_valid = r_rd_valid;
  end

  assign o_level      = w_level;
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_afull      = (w_level >= LP_AFULL_TH);
  assign o_aempty     = (w_level <= LP_AEMPTY_TH);
  assign o_overflow   = w_overflow;
  assign o_underflow  = w_underflow;
  assign o_ovf_sticky = r_ovf_sticky;
  assign o_udf_sticky = r_udf_sticky;

`ifndef SYNTHESIS
  // Flags must never contradict each other or the level.
  a_level_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_level <= LP_FULL_LVL);
  a_not_full_and_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_full && w_empty));
  a_full_implies_afull: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_full |-> o_afull);
  a_empty_implies_aempty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_empty |-> o_aempty);

  // Pointers move by exactly one on an accepted request and hold otherwise.
  a_wr_ptr_inc: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_wr_accept |=> (r_wr_ptr == $past(r_wr_ptr) + 1'b1));
  a_wr_ptr_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !w_wr_accept |=> $stable(r_wr_ptr));
  a_rd_ptr_inc: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_rd_accept |=> (r_rd_ptr == $past(r_rd_ptr) + 1'b1));
  a_rd_ptr_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !w_rd_accept |=> $stable(r_rd_ptr));

  // Sticky flags set on the event, hold without a clear, drop on a clear alone.
  a_ovf_set: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_overflow |=> r_ovf_sticky);
  a_ovf_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_ovf_sticky && !i_clr_err) |=> r_ovf_sticky);
  a_ovf_clr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_clr_err && !w_overflow) |=> !r_ovf_sticky);
  a_udf_set: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    w_underflow |=> r_udf_sticky);
  a_udf_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_udf_sticky && !i_clr_err) |=> r_udf_sticky);
  a_udf_clr: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_clr_err && !w_underflow) |=> !r_udf_sticky);
`endif

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Bench for fifo_sync_ext: a registered-read and an FWFT instance share the same stimulus.
// Latency: checks combinational pulses mid-cycle and registered state 1 ns after each edge.
// Backpressure: model accepts/rejects requests from occupancy rules using a queue.
module tb_fifo_sync_ext;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic       clr;
  logic [7:0] din;

  logic [7:0] d0_data, d1_data;
  logic       d0_rv, d1_rv, d0_full, d1_full, d0_empty, d1_empty;
  logic       d0_afull, d1_afull, d0_aempty, d1_aempty;
  logic [2:0] d0_level, d1_level;
  logic       d0_ovf, d1_ovf, d0_udf, d1_udf;
  logic       d0_ovfs, d1_ovfs, d0_udfs, d1_udfs;

  always #5 clk = ~clk;

  fifo_sync_ext #(.G_WIDTH(8), .G_DEPTH(2), .G_FWFT(0), .G_AFULL_TH(3), .G_AEMPTY_TH(1)) u_dut_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(din), .i_rd(rd), .i_clr_err(clr),
    .o_data(d0_data), .o_rd_valid(d0_rv), .o_full(d0_full), .o_empty(d0_empty),
    .o_afull(d0_afull), .o_aempty(d0_aempty), .o_level(d0_level),
    .o_overflow(d0_ovf), .o_underflow(d0_udf), .o_ovf_sticky(d0_ovfs), .o_udf_sticky(d0_udfs)
  );

  fifo_sync_ext #(.G_WIDTH(8), .G_DEPTH(2), .G_FWFT(1), .G_AFULL_TH(3), .G_AEMPTY_TH(1)) u_dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(din), .i_rd(rd), .i_clr_err(clr),
    .o_data(d1_data), .o_rd_valid(d1_rv), .o_full(d1_full), .o_empty(d1_empty),
    .o_afull(d1_afull), .o_aempty(d1_aempty), .o_level(d1_level),
    .o_overflow(d1_ovf), .o_underflow(d1_udf), .o_ovf_sticky(d1_ovfs), .o_udf_sticky(d1_udfs)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: contents as a queue, plus the registered-read output and error flags.
  logic [7:0] mq[$];
  logic       m_ovfs = 1'b0;
  logic       m_udfs = 1'b0;
  logic       m_rv   = 1'b0;
  logic [7:0] m_data = 8'h00;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic [2:0] lvl;
    logic       afull;
    logic       full;
    logic       ovf;
    logic       udf;
    logic       rv;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[13];
  logic c_ovf, c_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare both instances against the model after a clock edge.
  task automatic check_state();
    int sz;
    sz = mq.size();
    chk("level_reg",  32'(d0_level),  32'(sz));
    chk("level_fwft", 32'(d1_level),  32'(sz));
    chk("empty_reg",  32'(d0_empty),  32'(sz == 0));
    chk("empty_fwft", 32'(d1_empty),  32'(sz == 0));
    chk("full_reg",   32'(d0_full),   32'(sz == 4));
    chk("full_fwft",  32'(d1_full),   32'(sz == 4));
    chk("afull_reg",  32'(d0_afull),  32'(sz >= 3));
    chk("afull_fwft", 32'(d1_afull),  32'(sz >= 3));
    chk("aempty_reg", 32'(d0_aempty), 32'(sz <= 1));
    chk("aempty_fwft",32'(d1_aempty), 32'(sz <= 1));
    chk("ovfs_reg",   32'(d0_ovfs),   32'(m_ovfs));
    chk("udfs_reg",   32'(d0_udfs),   32'(m_udfs));
    chk("ovfs_fwft",  32'(d1_ovfs),   32'(m_ovfs));
    chk("udfs_fwft",  32'(d1_udfs),   32'(m_udfs));
    chk("rvalid_reg", 32'(d0_rv),     32'(m_rv));
    chk("data_reg",   32'(d0_data),   32'(m_data));
    chk("rvalid_fwft",32'(d1_rv),     32'(sz > 0));
    if (sz > 0) chk("data_fwft", 32'(d1_data), 32'(mq[0]));
  endtask

  // One clock of stimulus: drive, check the combinational pulses, clock, update model, check state.
  task automatic cycle(input logic a_rst_n, input logic a_wr, input logic [7:0] a_d,
                       input logic a_rd, input logic a_clr,
                       output logic o_ovf_seen, output logic o_udf_seen);
    int   sz;
    logic rd_acc, wr_acc, e_ovf, e_udf;
    rst_n = a_rst_n; wr = a_wr; din = a_d; rd = a_rd; clr = a_clr;
    #3;
    sz     = mq.size();
    rd_acc = a_rd && (sz > 0);
    wr_acc = a_wr && ((sz < 4) || rd_acc);
    e_ovf  = a_wr && (sz == 4) && !rd_acc;
    e_udf  = a_rd && (sz == 0);
    o_ovf_seen = d0_ovf;
    o_udf_seen = d0_udf;
    if (a_rst_n) begin
      chk("overflow_reg",   32'(d0_ovf), 32'(e_ovf));
      chk("underflow_reg",  32'(d0_udf), 32'(e_udf));
      chk("overflow_fwft",  32'(d1_ovf), 32'(e_ovf));
      chk("underflow_fwft", 32'(d1_udf), 32'(e_udf));
    end
    @(posedge clk);
    #1;
    if (!a_rst_n) begin
      mq.delete();
      m_ovfs = 1'b0; m_udfs = 1'b0; m_rv = 1'b0; m_data = 8'h00;
    end else begin
      m_rv = rd_acc;
      if (rd_acc) m_data = mq.pop_front();
      if (wr_acc) mq.push_back(a_d);
      if (e_ovf) m_ovfs = 1'b1; else if (a_clr) m_ovfs = 1'b0;
      if (e_udf) m_udfs = 1'b1; else if (a_clr) m_udfs = 1'b0;
    end
    check_state();
  endtask

  initial begin
    // wr, d, rd | level, afull, full, ovf, udf, rvalid, data (registered-read instance)
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'h66, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'h55, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55};
    tbl[10] = '{1'b1, 8'hA5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};

    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = 8'h00;
    @(posedge clk);
    #1;

    // Reset, including one cycle with requests present that must be ignored.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, c_ovf, c_udf);
    cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, c_ovf, c_udf);
    chk("rst_level",  32'(d0_level),  32'd0);
    chk("rst_empty",  32'(d0_empty),  32'd1);
    chk("rst_aempty", 32'(d0_aempty), 32'd1);
    chk("rst_full",   32'(d0_full),   32'd0);
    chk("rst_afull",  32'(d0_afull),  32'd0);

    // Fill, overflow, write-through-full, drain, empty write+read.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0, c_ovf, c_udf);
      chk($sformatf("tbl%0d_ovf", i),   32'(c_ovf),    32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),   32'(c_udf),    32'(tbl[i].udf));
      chk($sformatf("tbl%0d_level", i), 32'(d0_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_afull", i), 32'(d0_afull), 32'(tbl[i].afull));
      chk($sformatf("tbl%0d_full", i),  32'(d0_full),  32'(tbl[i].full));
      chk($sformatf("tbl%0d_rv", i),    32'(d0_rv),    32'(tbl[i].rv));
      chk($sformatf("tbl%0d_data", i),  32'(d0_data),  32'(tbl[i].data));
    end
    chk("seq_ovf_sticky", 32'(d0_ovfs), 32'd1);

    // Clear racing an underflow: the new event keeps the flag set.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, c_ovf, c_udf);
    chk("clr_udfs_cleared", 32'(d0_udfs), 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, c_ovf, c_udf);
    chk("clr_race_udf", 32'(c_udf), 32'd1);
    chk("clr_race_udfs", 32'(d0_udfs), 32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, c_ovf, c_udf);
    chk("clr_alone_udfs", 32'(d0_udfs), 32'd0);

    // FWFT: a word written into an empty FIFO shows up next cycle, i_rd pops it.
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, c_ovf, c_udf);
    chk("fwft_data", 32'(d1_data), 32'h5A);
    chk("fwft_rv",   32'(d1_rv),   32'd1);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, c_ovf, c_udf);
    chk("fwft_pop_empty", 32'(d1_empty), 32'd1);
    chk("fwft_pop_rv",    32'(d1_rv),    32'd0);

    // Pointer wrap, then reset with data in flight.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom_range(255)), 1'b0, 1'b0, c_ovf, c_udf);
      cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, c_ovf, c_udf);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, c_ovf, c_udf);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'($urandom_range(255)), 1'b0, 1'b0, c_ovf, c_udf);
    end
    chk("wrap_level3", 32'(d0_level), 32'd3);
    cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, c_ovf, c_udf);
    chk("wrap_rst_level", 32'(d0_level), 32'd0);
    chk("wrap_rst_empty", 32'(d0_empty), 32'd1);
    chk("wrap_rst_udfs",  32'(d0_udfs),  32'd0);
    chk("wrap_rst_ovfs",  32'(d0_ovfs),  32'd0);

    // Random traffic with alternating write-heavy and read-heavy phases.
    for (int k = 0; k < 600; k++) begin
      int   wr_pct;
      logic r_n, w, r, c;
      wr_pct = ((k / 50) % 2 == 0) ? 70 : 30;
      r_n = ($urandom_range(99) != 0);
      w   = ($urandom_range(99) < wr_pct);
      r   = ($urandom_range(99) < (100 - wr_pct));
      c   = ($urandom_range(15) == 0);
      cycle(r_n, w, 8'($urandom_range(255)), r, c, c_ovf, c_udf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
